// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared widths, segment codes and converter state encoding
//                for the count display block.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int DIGITS  = 3;
  localparam int COUNT_W = 7;
  localparam int BCD_W   = 12;
  localparam int SHIFT_W = BCD_W + COUNT_W;

  // Active-high segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter; blank them anyway
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, one bit per clock.
//                Starts a conversion whenever the input differs from the
//                last value converted; bcd updates only on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy
);

  localparam logic [2:0] c_LAST_ITER = 3'(COUNT_W - 1);

  conv_state_t        r_state,  w_state_nxt;
  logic [SHIFT_W-1:0] r_shift,  w_shift_nxt;
  logic [SHIFT_W-1:0] w_adj;
  logic [SHIFT_W-1:0] w_shifted;
  logic [COUNT_W-1:0] r_last,   w_last_nxt;
  logic [2:0]         r_iter,   w_iter_nxt;
  logic [BCD_W-1:0]   r_bcd,    w_bcd_nxt;
  logic               w_busy;

  // Add-3 correction on every BCD nibble that is 5 or more, then shift
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_shift[COUNT_W + 4*i +: 4] >= 4'd5) begin
        w_adj[COUNT_W + 4*i +: 4] = r_shift[COUNT_W + 4*i +: 4] + 4'd3;
      end
    end
    w_shifted = {w_adj[SHIFT_W-2:0], 1'b0};
  end

  // Next-state and busy; busy rises as soon as a start is pending in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_iter_nxt  = r_iter;
    w_bcd_nxt   = r_bcd;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bin != r_last) begin
          w_shift_nxt = {{BCD_W{1'b0}}, bin};
          w_last_nxt  = bin;
          w_iter_nxt  = 3'd0;
          w_state_nxt = CONV;
          w_busy      = 1'b1;
        end
      end
      CONV: begin
        w_busy      = 1'b1;
        w_shift_nxt = w_shifted;
        w_iter_nxt  = r_iter + 3'd1;
        if (r_iter == c_LAST_ITER) begin
          w_bcd_nxt   = w_shifted[SHIFT_W-1:COUNT_W];
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Converter state register; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_last  <= '0;
      r_iter  <= 3'd0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
      r_iter  <= w_iter_nxt;
      r_bcd   <= w_bcd_nxt;
    end
  end

  assign bcd  = r_bcd;
  assign busy = w_busy;

endmodule
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
// ============================================================================
//  Module      : count_display
//  Description : Samples the 7-bit count bus, converts it to BCD and scans
//                it onto a 3-digit multiplexed seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] count,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  an,
  output logic [BCD_W-1:0]   bcd,
  output logic               busy
);

  localparam int               c_PRE_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0]        c_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] c_AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [COUNT_W-1:0] r_count_q;
  logic [c_PRE_W-1:0] r_pre;
  logic [1:0]         r_digit;
  logic [6:0]         r_seg;
  logic [DIGITS-1:0]  r_an;

  logic [3:0]         w_nib;
  logic               w_blank;
  logic [6:0]         w_seg;
  logic [DIGITS-1:0]  w_an;

  // Single sampled copy of the count bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_count_q <= '0;
    else      r_count_q <= count;
  end

  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (r_count_q),
    .bcd  (bcd),
    .busy (busy)
  );

  // Prescaler and digit index: each digit stays selected SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_digit <= 2'd0;
    end else if (r_pre == c_PRE_MAX) begin
      r_pre   <= '0;
      r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
    end else begin
      r_pre   <= r_pre + c_PRE_W'(1);
    end
  end

  // Digit select, leading-zero blanking, decode and polarity
  always_comb begin
    w_nib   = bcd[3:0];
    w_blank = 1'b0;
    case (r_digit)
      2'd0: w_nib = bcd[3:0];
      2'd1: begin
        w_nib   = bcd[7:4];
        w_blank = BLANK_LEADING && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      default: begin
        w_nib   = bcd[11:8];
        w_blank = BLANK_LEADING && (bcd[11:8] == 4'd0);
      end
    endcase
    w_seg = w_blank ? SEG_OFF : seg_decode(w_nib);
    w_an  = 3'b001 << r_digit;
    if (SEG_ACTIVE_LOW) begin
      w_seg = ~w_seg;
      w_an  = ~w_an;
    end
  end

  // Enable and segments registered together so they always match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= c_SEG_OFF;
      r_an  <= c_AN_OFF;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_count_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_count_display
//  Description : Scoreboard bench for count_display: conversions, latency,
//                busy width, scan timing, blanking and polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  count = 7'd0;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  an_a, an_b;
  logic [11:0] bcd_a, bcd_b;
  logic        busy_a, busy_b;

  count_display #(.SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .count(count), .seg(seg_a), .an(an_a), .bcd(bcd_a), .busy(busy_a)
  );

  count_display #(.SCAN_DIV(SCAN), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .count(count), .seg(seg_b), .an(an_b), .bcd(bcd_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int val;
    int done;
  } exp_t;

  exp_t sb_q[$];
  exp_t tl_q[$];
  exp_t e_pop;
  exp_t t_pop;

  int  last_val  = 0;
  int  prev_done = 0;
  int  rel_edge  = 0;
  int  cur_val   = 0;
  int  brun      = 0;
  bit  chk_busy  = 1'b0;
  logic [11:0] prev_bcd = 12'h000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bcd_of(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int seg_code(input int d);
    case (d)
      0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F; 4: return 'h66;
      5: return 'h6D; 6: return 'h7D; 7: return 'h07; 8: return 'h7F; 9: return 'h6F;
      default: return 0;
    endcase
  endfunction

  // Expected display for a decimal value, digit position, blanking and polarity
  function automatic int exp_seg(input int v, input int dig, input bit blank, input bit al);
    int h, t, o, d, s;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    d = (dig == 0) ? o : (dig == 1) ? t : h;
    s = seg_code(d);
    if (blank && ((dig == 2 && h == 0) || (dig == 1 && h == 0 && t == 0))) s = 0;
    return al ? (~s & 'h7F) : s;
  endfunction

  function automatic int exp_an(input int dig, input bit al);
    int a;
    a = 1 << dig;
    return al ? (~a & 'h7) : a;
  endfunction

  // A conversion starts one edge after the value is sampled, or one edge
  // after the previous conversion finishes, whichever is later; it lasts 7 edges
  task automatic note(input int v);
    exp_t e;
    int st;
    if (v != last_val) begin
      st = edge_n + 2;
      if (prev_done + 1 > st) st = prev_done + 1;
      e.val  = v;
      e.done = st + 7;
      sb_q.push_back(e);
      tl_q.push_back(e);
      prev_done = e.done;
      last_val  = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_count(input int v);
    count = 7'(v);
    note(v);
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    sb_q.delete();
    tl_q.delete();
    last_val = 0;
    cur_val  = 0;
  endtask

  task automatic release_reset();
    rst       = 1'b1;
    rel_edge  = edge_n;
    prev_done = edge_n;
    note(int'(count));
  endtask

  // Monitor: scoreboard on bcd updates, busy width, and scan/segment model
  always @(negedge clk) begin
    int dig;
    if (!rst) begin
      prev_bcd = 12'h000;
      brun     = 0;
      chk("rst_an_al",  an_a,  'h7);
      chk("rst_seg_al", seg_a, 'h7F);
      chk("rst_an_ah",  an_b,  0);
      chk("rst_seg_ah", seg_b, 0);
    end else begin
      if (bcd_a !== prev_bcd) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bcd_unexpected: got %0h expected no update (t=%0t)", bcd_a, $time);
        end else begin
          e_pop = sb_q.pop_front();
          chk("bcd_value", int'(bcd_a), bcd_of(e_pop.val));
          chk("bcd_latency_edge", edge_n, e_pop.done);
        end
        prev_bcd = bcd_a;
      end

      if (busy_a) begin
        brun++;
      end else begin
        if (brun != 0 && chk_busy) chk("busy_width", brun, 8);
        brun = 0;
      end

      while (tl_q.size() > 0 && tl_q[0].done <= edge_n - 1) begin
        t_pop   = tl_q.pop_front();
        cur_val = t_pop.val;
      end
      if (edge_n == rel_edge) begin
        chk("pre_edge_an_al",  an_a,  'h7);
        chk("pre_edge_seg_al", seg_a, 'h7F);
        chk("pre_edge_an_ah",  an_b,  0);
        chk("pre_edge_seg_ah", seg_b, 0);
      end else begin
        dig = ((edge_n - rel_edge - 1) / SCAN) % 3;
        chk("scan_an_al",  an_a,  exp_an(dig, 1'b1));
        chk("scan_seg_al", seg_a, exp_seg(cur_val, dig, 1'b1, 1'b1));
        chk("scan_an_ah",  an_b,  exp_an(dig, 1'b0));
        chk("scan_seg_ah", seg_b, exp_seg(cur_val, dig, 1'b0, 1'b0));
      end
    end
  end

  initial begin
    // Reset state
    assert_reset();
    repeat (3) step();
    chk("rst_bcd",  bcd_a,  0);
    chk("rst_busy", busy_a, 0);
    release_reset();
    chk_busy = 1'b1;

    // Zero with leading blanking, full scan rotation
    repeat (14) step();

    // Maximum value
    set_count(127);
    repeat (40) step();

    // Single digit
    set_count(5);
    repeat (16) step();

    // Change arrives mid-conversion; back-to-back conversions
    chk_busy = 1'b0;
    set_count(45);
    repeat (4) step();
    set_count(100);
    repeat (25) step();
    chk_busy = 1'b1;

    // Asynchronous reset during a conversion
    set_count(99);
    repeat (4) step();
    assert_reset();
    #1;
    chk("async_rst_busy",   busy_a, 0);
    chk("async_rst_bcd",    bcd_a,  0);
    chk("async_rst_an",     an_a,   'h7);
    chk("async_rst_seg",    seg_a,  'h7F);
    chk("async_rst_an_ah",  an_b,   0);
    repeat (2) step();
    release_reset();
    repeat (30) step();

    // Zero again, scan timing
    set_count(0);
    repeat (30) step();

    // Randomized values with holds long enough for isolated conversions
    for (int i = 0; i < 30; i++) begin
      set_count(int'($urandom_range(0, 127)));
      repeat ($urandom_range(10, 14)) step();
    end

    repeat (12) step();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
